// File: rtl/video_out_gen.sv
// video_out_gen: pops grey pixels from a first-word-fall-through FIFO and
// emits a raster stream (line_valid / frame_valid / pixel_out). Active slots
// are never stretched; a slot that finds the FIFO empty outputs 0 and pulses
// underflow.
module video_out_gen #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int H_BLANK = 160,
    parameter int V_BLANK = 40
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       empty,
    input  logic [7:0] pixel_in,
    output logic       r_e,
    output logic       frame_valid,
    output logic       line_valid,
    output logic [7:0] pixel_out,
    output logic       underflow
);

    localparam int H_TOTAL = WIDTH + H_BLANK;
    localparam int V_MAX   = (HEIGHT > V_BLANK) ? HEIGHT : V_BLANK;
    localparam int H_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int V_W     = (V_MAX > 1) ? $clog2(V_MAX) : 1;

    localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT      = H_W'(WIDTH);
    localparam logic [V_W-1:0] V_ACT_LAST = V_W'(HEIGHT - 1);
    localparam logic [V_W-1:0] V_BLK_LAST = V_W'(V_BLANK - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        VBLANK
    } state_t;

    state_t         state, state_next;
    logic [H_W-1:0] h_cnt, h_next;
    logic [V_W-1:0] v_cnt, v_next;
    logic           slot;

    // A pixel slot exists only in the active frame, left of the h-blank.
    assign slot = (state == ACTIVE) && (h_cnt < H_ACT);
    // The pop is combinational so the FIFO head is consumed in the slot itself.
    assign r_e  = slot && !empty;

    // State and raster counters.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            state <= state_next;
            h_cnt <= h_next;
            v_cnt <= v_next;
        end
    end

    // Next-state and counter stepping; wrap of h_cnt advances v_cnt.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        state_next = state;
        h_next     = h_cnt;
        v_next     = v_cnt;
        case (state)
            IDLE: begin
                h_next = '0;
                v_next = '0;
                if (!empty) state_next = ACTIVE;
            end
            ACTIVE, VBLANK: begin
                if (h_cnt == H_LAST) begin
                    h_next = '0;
                    if (state == ACTIVE && v_cnt == V_ACT_LAST) begin
                        v_next     = '0;
                        state_next = VBLANK;
                    end else if (state == VBLANK && v_cnt == V_BLK_LAST) begin
                        v_next     = '0;
                        state_next = IDLE;
                    end else begin
                        v_next = v_cnt + V_W'(1);
                    end
                end else begin
                    h_next = h_cnt + H_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered video outputs, one cycle behind the slot that produced them.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            frame_valid <= 1'b0;
            line_valid  <= 1'b0;
            pixel_out   <= 8'd0;
            underflow   <= 1'b0;
        end else begin
            frame_valid <= (state == ACTIVE);
            line_valid  <= slot;
            pixel_out   <= r_e ? pixel_in : 8'd0;
            underflow   <= slot && empty;
        end
    end

endmodule

// File: tb/tb_video_out_gen.sv
// Self-checking bench for video_out_gen: a queue-based FIFO model feeds the
// DUT, a raster reference model predicts outputs into scoreboard queues and a
// negedge monitor compares whatever the DUT presents.
module tb_video_out_gen;

    localparam int WIDTH   = 8;
    localparam int HEIGHT  = 4;
    localparam int H_BLANK = 4;
    localparam int V_BLANK = 2;
    localparam int L       = WIDTH + H_BLANK;
    localparam int FRAME   = (HEIGHT + V_BLANK) * L;

    typedef struct {
        logic fv;
        logic lv;
    } ctl_t;

    typedef struct {
        logic [7:0] px;
        logic       uf;
    } pix_t;

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic       empty = 1'b1;
    logic [7:0] pixel_in = 8'd0;
    logic       r_e, frame_valid, line_valid, underflow;
    logic [7:0] pixel_out;

    video_out_gen #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .H_BLANK(H_BLANK), .V_BLANK(V_BLANK)
    ) dut (
        .clk(clk), .nRST(nRST), .empty(empty), .pixel_in(pixel_in),
        .r_e(r_e), .frame_valid(frame_valid), .line_valid(line_valid),
        .pixel_out(pixel_out), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] fifo_q[$];
    ctl_t       ctl_q[$];
    pix_t       pix_q[$];
    int         rise_q[$];

    // reference model state: idle flag and cycle offset inside the frame
    bit m_idle = 1'b1;
    int m_fc = 0;
    int m_uf_slots = 0;
    int n_pops = 0;
    int n_uf = 0;
    int cyc = 0;
    bit prev_fv = 1'b0;
    bit pop_now = 1'b0;
    bit blank_empty = 1'b0;
    bit rand_empty = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: pops expectations whenever the DUT presents output.
    always @(negedge clk) begin
        ctl_t c;
        pix_t p;
        cyc++;
        if (frame_valid && !prev_fv) rise_q.push_back(cyc);
        prev_fv = frame_valid;
        if (underflow) n_uf++;
        if (ctl_q.size() == 0) check("ctl_queue_nonempty", 0, 1);
        else begin
            c = ctl_q.pop_front();
            check("frame_valid", frame_valid, c.fv);
            check("line_valid", line_valid, c.lv);
        end
        if (line_valid) begin
            if (pix_q.size() == 0) check("pix_queue_nonempty", 0, 1);
            else begin
                p = pix_q.pop_front();
                check("pixel_out", pixel_out, p.px);
                check("underflow", underflow, p.uf);
            end
        end else begin
            check("pixel_out_blank", pixel_out, 0);
            check("underflow_blank", underflow, 0);
        end
    end

    // Apply FIFO contents and empty-forcing policy to the DUT inputs.
    task automatic drive();
        bit in_slot;
        bit force_e;
        in_slot = !m_idle && (m_fc / L < HEIGHT) && (m_fc % L < WIDTH);
        force_e = (blank_empty && !m_idle && !in_slot) ||
                  (rand_empty && $urandom_range(0, 3) == 0);
        empty    = (fifo_q.size() == 0) || force_e;
        pixel_in = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
    endtask

    // One clock cycle: evaluate the reference model, then let the edge pop.
    task automatic step();
        ctl_t c;
        pix_t p;
        bit   exp_re;
        @(negedge clk);
        #1;
        exp_re = 1'b0;
        c.fv = 1'b0;
        c.lv = 1'b0;
        if (!nRST) begin
            m_idle = 1'b1;
            m_fc = 0;
        end else if (m_idle) begin
            if (!empty) begin
                m_idle = 1'b0;
                m_fc = 0;
            end
        end else begin
            c.fv = (m_fc / L) < HEIGHT;
            c.lv = c.fv && (m_fc % L) < WIDTH;
            exp_re = c.lv && !empty;
            if (c.lv) begin
                p.px = empty ? 8'd0 : pixel_in;
                p.uf = empty;
                pix_q.push_back(p);
                if (empty) m_uf_slots++;
            end
            m_fc++;
            if (m_fc == FRAME) m_idle = 1'b1;
        end
        ctl_q.push_back(c);
        check("r_e", r_e, exp_re);
        pop_now = r_e;
        @(posedge clk);
        #1;
        if (pop_now) begin
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            n_pops++;
        end
        drive();
    endtask

    task automatic push_random(input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(8'($urandom));
        drive();
    endtask

    // Run until a frame has started and finished, bounded in cycles.
    task automatic run_frame();
        int budget;
        budget = 50;
        while (m_idle && budget > 0) begin step(); budget--; end
        if (m_idle) check("frame_start_timeout", 0, 1);
        budget = FRAME + 10;
        while (!m_idle && budget > 0) begin step(); budget--; end
        if (!m_idle) check("frame_end_timeout", 0, 1);
    endtask

    initial begin
        ctl_t z;
        int   pops0, uf0, budget;
        z.fv = 1'b0;
        z.lv = 1'b0;
        ctl_q.push_back(z);

        // reset, then an empty FIFO: nothing may start
        nRST = 1'b0;
        drive();
        repeat (5) step();
        nRST = 1'b1;
        repeat (50) step();
        check("idle_no_pops", n_pops, 0);
        check("idle_stays_idle", m_idle, 1);

        // ramp 0..31, never empty
        for (int i = 0; i < 32; i++) fifo_q.push_back(8'(i));
        drive();
        pops0 = n_pops;
        run_frame();
        check("ramp_pops", n_pops - pops0, 32);

        // underflow inside line 0 at pixel 5, refill three cycles later
        for (int i = 0; i < 5; i++) fifo_q.push_back(8'(8'h10 + i));
        drive();
        uf0 = n_uf;
        m_uf_slots = 0;
        budget = 60;
        while (m_uf_slots < 3 && budget > 0) begin step(); budget--; end
        check("uf_slots_seen", m_uf_slots, 3);
        push_random(24);
        run_frame();
        repeat (2) step();
        check("uf_pulse_count", n_uf - uf0, 3);
        check("uf_fifo_drained", fifo_q.size(), 0);

        // empty asserted throughout blanking while data is waiting
        blank_empty = 1'b1;
        push_random(32);
        uf0 = n_uf;
        run_frame();
        blank_empty = 1'b0;
        repeat (2) step();
        check("blank_no_underflow", n_uf - uf0, 0);
        check("blank_no_data_lost", fifo_q.size(), 0);

        // random empty toggling inside lines
        rand_empty = 1'b1;
        push_random(32);
        run_frame();
        rand_empty = 1'b0;
        fifo_q.delete();
        drive();
        repeat (2) step();

        // reset mid-frame at line 2 pixel 3
        push_random(32);
        budget = 200;
        while ((m_idle || m_fc != 2 * L + 4) && budget > 0) begin step(); budget--; end
        check("reached_line2_px3", m_fc, 2 * L + 4);
        nRST = 1'b0;
        ctl_q.delete();
        pix_q.delete();
        ctl_q.push_back(z);
        drive();
        repeat (5) step();
        nRST = 1'b1;
        push_random(20);
        pops0 = n_pops;
        run_frame();
        check("post_reset_pops", n_pops - pops0, 32);

        // back-to-back frames with the FIFO always stocked
        push_random(64);
        rise_q.delete();
        pops0 = n_pops;
        run_frame();
        check("b2b_first_pops", n_pops - pops0, 32);
        run_frame();
        repeat (3) step();
        check("b2b_rise_count", rise_q.size(), 2);
        if (rise_q.size() >= 2) check("frame_period", rise_q[1] - rise_q[0], FRAME + 1);
        check("b2b_total_pops", n_pops - pops0, 64);
        check("scoreboard_drained", pix_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
